// File: rtl/i2c_slv_l2_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_slv_l2_wr_ctrl                                           |
// | Description : Turns the I2C slave RX byte stream into 32-bit word writes   |
// |               on an OBI-style L2 port. Each frame carries a 4-byte LE base |
// |               address, then payload bytes packed LE into words written at  |
// |               auto-incrementing addresses inside a permitted L2 window.    |
// | Ports       : clk_i/rst_ni        clock, async active-low reset            |
// |               start_i/stop_i      START/STOP pulses from the I2C slave     |
// |               rx_valid_i/rx_data_i/rx_ready_o  RX byte handshake           |
// |               mem_req_o/mem_gnt_i/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o |
// |                                   L2 write port                            |
// |               busy_o              controller not idle                      |
// |               err_o/clr_i         sticky error, clear (also clears words)  |
// |               words_o             saturating count of granted writes       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_slv_l2_wr_ctrl #(
    parameter logic [31:0] WIN_BASE = 32'h1C00_0000,
    parameter logic [31:0] WIN_SIZE = 32'h0008_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    output logic             rx_ready_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    output logic             busy_o,
    output logic             err_o,
    input  logic             clr_i,
    output logic [CNT_W-1:0] words_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_WR   = 2'd3;

    // 33-bit bounds so a window touching the top of the address space cannot wrap
    localparam logic [32:0] c_WIN_LO  = {1'b0, WIN_BASE};
    localparam logic [32:0] c_WIN_HI  = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [1:0]       r_lane;
    logic [1:0]       r_idx;
    logic             r_stop_pend;
    logic             r_start_pend;
    logic             r_err;
    logic [CNT_W-1:0] r_words;
    logic             r_rdy_en;   // keeps rx_ready_o low while in reset

    logic             w_wr;
    logic             w_in_win;
    logic             w_rx_fire;
    logic             w_wr_done;
    logic [CNT_W-1:0] w_words_inc;

    assign w_wr       = (r_state == c_ST_WR);
    assign w_in_win   = ({1'b0, r_addr} >= c_WIN_LO) && ({1'b0, r_addr} < c_WIN_HI);
    // Out-of-window words never raise a request; WR is left as if granted.
    assign w_wr_done  = w_wr & (~w_in_win | mem_gnt_i);
    assign w_rx_fire  = rx_valid_i & rx_ready_o;
    assign w_words_inc = (r_words == {CNT_W{1'b1}}) ? r_words : r_words + c_CNT_ONE;

    assign rx_ready_o  = r_rdy_en & ~w_wr;
    assign mem_req_o   = w_wr & w_in_win;
    assign mem_we_o    = mem_req_o;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;
    assign busy_o      = (r_state != c_ST_IDLE);
    assign err_o       = r_err;
    assign words_o     = r_words;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= c_ST_IDLE;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_lane       <= 2'd0;
            r_idx        <= 2'd0;
            r_stop_pend  <= 1'b0;
            r_start_pend <= 1'b0;
            r_err        <= 1'b0;
            r_words      <= '0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            // Clear first; any error set or grant below overrides it this cycle.
            if (clr_i) begin
                r_err   <= 1'b0;
                r_words <= '0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_state <= c_ST_ADDR;
                        r_idx   <= 2'd0;
                    end
                end

                c_ST_ADDR: begin
                    if (start_i) begin
                        r_idx <= 2'd0;
                    end else begin
                        if (w_rx_fire) begin
                            r_addr[{r_idx, 3'b000} +: 8] <= rx_data_i;
                            r_idx <= r_idx + 2'd1;
                            if (r_idx == 2'd3) begin
                                r_addr[1:0] <= 2'b00;
                                if (r_addr[1:0] != 2'b00) r_err <= 1'b1;
                                r_state <= c_ST_DATA;
                                r_lane  <= 2'd0;
                                r_be    <= 4'd0;
                                r_wdata <= 32'd0;
                            end
                        end
                        // A stop landing with the 4th address byte is an empty frame, not an abort.
                        if (stop_i) begin
                            r_state <= c_ST_IDLE;
                            if (!(w_rx_fire && (r_idx == 2'd3))) r_err <= 1'b1;
                        end
                    end
                end

                c_ST_DATA: begin
                    if (start_i) begin
                        if (r_lane != 2'd0) r_err <= 1'b1;
                        r_state <= c_ST_ADDR;
                        r_idx   <= 2'd0;
                        r_lane  <= 2'd0;
                        r_be    <= 4'd0;
                        r_wdata <= 32'd0;
                    end else if (w_rx_fire) begin
                        r_wdata[{r_lane, 3'b000} +: 8] <= rx_data_i;
                        r_be[r_lane] <= 1'b1;
                        r_lane       <= r_lane + 2'd1;
                        if ((r_lane == 2'd3) || stop_i) begin
                            r_state      <= c_ST_WR;
                            r_stop_pend  <= stop_i;
                            r_start_pend <= 1'b0;
                        end
                    end else if (stop_i) begin
                        if (r_lane != 2'd0) begin
                            r_state      <= c_ST_WR;
                            r_stop_pend  <= 1'b1;
                            r_start_pend <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end

                c_ST_WR: begin
                    if (stop_i)  r_stop_pend  <= 1'b1;
                    if (start_i) r_start_pend <= 1'b1;
                    if (w_wr_done) begin
                        if (!w_in_win) r_err   <= 1'b1;
                        else           r_words <= clr_i ? c_CNT_ONE : w_words_inc;
                        r_addr       <= r_addr + 32'd4;
                        r_lane       <= 2'd0;
                        r_be         <= 4'd0;
                        r_wdata      <= 32'd0;
                        r_stop_pend  <= 1'b0;
                        r_start_pend <= 1'b0;
                        // Events seen in the grant cycle itself count as pending too.
                        if (r_start_pend || start_i) begin
                            r_state <= c_ST_ADDR;
                            r_idx   <= 2'd0;
                        end else if (r_stop_pend || stop_i) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_DATA;
                        end
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slv_l2_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_slv_l2_wr_ctrl                                        |
// | Description : Self-checking bench: vector table of frames, hand-written    |
// |               corner sequences, random frames against a frame-level model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_i2c_slv_l2_wr_ctrl;

    localparam logic [31:0] WIN_BASE = 32'h1C00_0000;
    localparam logic [31:0] WIN_SIZE = 32'h0008_0000;
    localparam int          CNT_W    = 16;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        int          n;
        logic [63:0] data;
        int          gdly;
        int          exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             rx_valid_i = 1'b0;
    logic [7:0]       rx_data_i = 8'd0;
    logic             rx_ready_o;
    logic             mem_req_o;
    logic             mem_gnt_i = 1'b0;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic [3:0]       mem_be_o;
    logic             busy_o;
    logic             err_o;
    logic             clr_i = 1'b0;
    logic [CNT_W-1:0] words_o;

    int  total = 0;
    int  bad   = 0;
    int  gnt_delay = 0;
    int  wait_cnt  = 0;
    bit  rand_gnt  = 1'b0;

    logic [7:0] tx_q[$];
    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic       exp_err;

    i2c_slv_l2_wr_ctrl #(
        .WIN_BASE (WIN_BASE),
        .WIN_SIZE (WIN_SIZE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .clr_i       (clr_i),
        .words_o     (words_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int j = 0; j < 4; j++) if (be[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    // Grant after gnt_delay wait cycles of an outstanding request.
    always @(negedge clk) begin
        if (mem_req_o && !mem_gnt_i && wait_cnt >= gnt_delay) begin
            mem_gnt_i = 1'b1;
            wait_cnt  = 0;
            if (rand_gnt) gnt_delay = $urandom_range(0, 3);
        end else begin
            mem_gnt_i = 1'b0;
            if (mem_req_o) wait_cnt++;
            else           wait_cnt = 0;
        end
    end

    // Bus monitor: capture granted writes, check request hold and RX stall.
    logic        p_req = 1'b0, p_gnt = 1'b0;
    logic [31:0] p_addr, p_wd;
    logic [3:0]  p_be;
    always @(posedge clk) begin
        if (!rst_ni) begin
            p_req = 1'b0;
        end else begin
            if (p_req && !p_gnt) begin
                chk("req_hold_ctl", {mem_req_o, mem_be_o}, {1'b1, p_be});
                chk("req_hold_dat", {mem_addr_o, mem_wdata_o}, {p_addr, p_wd});
            end
            if (mem_req_o) begin
                chk("wr_rx_ready", rx_ready_o, 1'b0);
                chk("wr_we", mem_we_o, 1'b1);
            end
            if (mem_req_o && mem_gnt_i) obs_q.push_back('{mem_addr_o, mem_wdata_o, mem_be_o});
            p_req = mem_req_o; p_gnt = mem_gnt_i;
            p_addr = mem_addr_o; p_wd = mem_wdata_o; p_be = mem_be_o;
        end
    end

    task automatic pulse_start();
        start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1; @(negedge clk); clr_i = 1'b0;
    endtask

    // Present a byte until accepted; optionally raise stop in the accepting cycle.
    task automatic send_byte(input logic [7:0] b, input bit with_stop);
        int n;
        n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_timeout", rx_ready_o, 1'b1);
        stop_i = with_stop;
        @(negedge clk);
        rx_valid_i = 1'b0;
        stop_i     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy_o, 1'b0);
    endtask

    task automatic send_addr(input logic [31:0] a);
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8], 1'b0);
    endtask

    task automatic run_frame(input logic [31:0] a, input bit stop_with_last);
        int n;
        n = tx_q.size();
        pulse_clr();
        obs_q.delete();
        pulse_start();
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(tx_q[i], stop_with_last && (i == n - 1));
        end
        if (!(stop_with_last && n > 0)) pulse_stop();
        wait_idle();
    endtask

    // Frame-level model: chunk payload into words at base+4k, window-filter them.
    task automatic model(input logic [31:0] a);
        logic [31:0] base, wa;
        wr_t         e;
        int          n;
        exp_q.delete();
        exp_err = (a[1:0] != 2'b00);
        base    = a & 32'hFFFF_FFFC;
        n       = tx_q.size();
        for (int k = 0; 4 * k < n; k++) begin
            wa = base + 32'(4 * k);
            e.a = wa; e.d = 32'd0; e.be = 4'd0;
            for (int j = 0; j < 4 && 4 * k + j < n; j++) begin
                e.d[8*j +: 8] = tx_q[4*k + j];
                e.be[j] = 1'b1;
            end
            if (wa >= WIN_BASE && (wa - WIN_BASE) < WIN_SIZE) exp_q.push_back(e);
            else exp_err = 1'b1;
        end
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_addr"}, obs_q[i].a, exp_q[i].a);
            chk({tag, "_be"}, obs_q[i].be, exp_q[i].be);
            chk({tag, "_data"}, obs_q[i].d & be_mask(exp_q[i].be), exp_q[i].d & be_mask(exp_q[i].be));
        end
        chk({tag, "_err"}, err_o, exp_err);
        chk({tag, "_words"}, words_o, exp_q.size());
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{32'h1C00_0000, 8, 64'h8877_6655_4433_2211, 0, 2, 32'h1C00_0004, 32'h8877_6655, 4'hF, 1'b0};
        vt[1] = '{32'h1C00_0010, 2, 64'h0000_0000_0000_BBAA, 3, 1, 32'h1C00_0010, 32'h0000_BBAA, 4'h3, 1'b0};
        vt[2] = '{32'h1000_0000, 4, 64'h0000_0000_4433_2211, 0, 0, 32'h0,         32'h0,         4'h0, 1'b1};
        vt[3] = '{32'h1C00_0002, 4, 64'h0000_0000_DDCC_BBAA, 1, 1, 32'h1C00_0000, 32'hDDCC_BBAA, 4'hF, 1'b1};
        vt[4] = '{32'h1C07_FFFC, 8, 64'h0807_0605_0403_0201, 0, 1, 32'h1C07_FFFC, 32'h0403_0201, 4'hF, 1'b1};
        vt[5] = '{32'h1BFF_FFFC, 8, 64'h0807_0605_0403_0201, 2, 1, 32'h1C00_0000, 32'h0807_0605, 4'hF, 1'b1};
        vt[6] = '{32'h1C00_0020, 0, 64'h0,                   0, 0, 32'h0,         32'h0,         4'h0, 1'b0};
        vt[7] = '{32'h1C00_0100, 5, 64'h0000_0055_4433_2211, 3, 2, 32'h1C00_0104, 32'h0000_0055, 4'h1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", rx_ready_o, 1'b0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_words", words_o, 0);
        chk("rst_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_ready", rx_ready_o, 1'b1);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            wr_t w;
            gnt_delay = vt[v].gdly;
            tx_q.delete();
            for (int i = 0; i < vt[v].n; i++) tx_q.push_back(vt[v].data[8*i +: 8]);
            run_frame(vt[v].addr, 1'b0);
            chk("vec_nwr", obs_q.size(), vt[v].exp_wr);
            if (vt[v].exp_wr > 0 && obs_q.size() > 0) begin
                w = obs_q[obs_q.size() - 1];
                chk("vec_addr", w.a, vt[v].exp_addr);
                chk("vec_be", w.be, vt[v].exp_be);
                chk("vec_data", w.d & be_mask(vt[v].exp_be), vt[v].exp_wdata & be_mask(vt[v].exp_be));
            end
            chk("vec_err", err_o, vt[v].exp_err);
            chk("vec_words", words_o, vt[v].exp_wr);
        end

        // Byte completing a word together with stop: full write then idle
        gnt_delay = 1;
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        model(32'h1C00_0200);
        run_frame(32'h1C00_0200, 1'b1);
        cmp_frame("byte_stop");

        // Backpressure: grant held off, rx_valid kept high, stop during WR
        gnt_delay = 10;
        pulse_clr(); obs_q.delete();
        pulse_start();
        send_addr(32'h1C00_0300);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
        chk("bp_req", mem_req_o, 1'b1);
        rx_valid_i = 1'b1; rx_data_i = 8'hEE;
        @(negedge clk);
        pulse_stop();
        wait_idle();
        repeat (3) @(negedge clk);
        rx_valid_i = 1'b0;
        chk("bp_nwr", obs_q.size(), 1);
        chk("bp_words", words_o, 1);
        chk("bp_busy", busy_o, 1'b0);
        if (obs_q.size() > 0) chk("bp_data", obs_q[0].d, 32'h1312_1110);

        // Abort in address phase, then clr
        gnt_delay = 0;
        pulse_clr(); obs_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        pulse_stop();
        wait_idle();
        chk("abort_err", err_o, 1'b1);
        chk("abort_nwr", obs_q.size(), 0);
        pulse_clr();
        chk("clr_err", err_o, 1'b0);

        // Repeated START mid-word restarts the frame and flags the lost bytes
        pulse_clr(); obs_q.delete();
        pulse_start();
        send_addr(32'h1C00_0400);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        pulse_start();
        tx_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        send_addr(32'h1C00_0040);
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b0);
        pulse_stop();
        wait_idle();
        model(32'h1C00_0040);
        exp_err = 1'b1;
        cmp_frame("restart");

        // START during WR: honoured after the grant
        gnt_delay = 5;
        pulse_clr(); obs_q.delete();
        pulse_start();
        send_addr(32'h1C00_0500);
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 1'b0);
        pulse_start();
        send_addr(32'h1C00_0600);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        pulse_stop();
        wait_idle();
        chk("swr_nwr", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("swr_a0", {obs_q[0].a, obs_q[0].d}, {32'h1C00_0500, 32'h5352_5150});
            chk("swr_a1", {obs_q[1].a, 28'd0, obs_q[1].be}, {32'h1C00_0600, 32'h3});
            chk("swr_d1", obs_q[1].d[15:0], 16'h6261);
        end
        chk("swr_err", err_o, 1'b0);

        // clr in the same cycle as a grant leaves words_o at 1
        gnt_delay = 3;
        pulse_clr(); obs_q.delete();
        pulse_start();
        send_addr(32'h1C00_0700);
        for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), 1'b0);
        repeat (3) @(negedge clk);
        pulse_clr();
        pulse_stop();
        wait_idle();
        chk("clrgnt_nwr", obs_q.size(), 2);
        chk("clrgnt_words", words_o, 1);

        // Reset while a request is outstanding
        gnt_delay = 20;
        pulse_clr(); obs_q.delete();
        pulse_start();
        send_addr(32'h1C00_0800);
        for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i), 1'b0);
        chk("rstmid_pre", mem_req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rstmid_req", {mem_req_o, mem_we_o, rx_ready_o, busy_o, err_o}, 5'd0);
        chk("rstmid_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
        chk("rstmid_be_words", {mem_be_o, words_o}, 20'd0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Randomized frames against the model
        rand_gnt = 1'b1;
        gnt_delay = 0;
        for (int f = 0; f < 40; f++) begin
            logic [31:0] a;
            int          n;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = WIN_BASE + 32'($urandom_range(0, 32'h1FFFF)) * 4;
                6:                a = WIN_BASE + WIN_SIZE - 32'(4 * $urandom_range(1, 2));
                7:                a = WIN_BASE - 32'd4;
                8:                a = WIN_BASE + 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
                default:          a = $urandom;
            endcase
            n = $urandom_range(0, 11);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            model(a);
            run_frame(a, 1'($urandom_range(0, 1)));
            cmp_frame("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
